cam_capture_444: RTL and testbench
==================================

# cam_capture_444

Camera-side writer for the 640x480 frame buffer that the VGA output path reads. Receives an OV7670-style parallel pixel stream (PCLK/VSYNC/HREF/8-bit data, RGB444 as two bytes per pixel), synchronises it into the CLK100MHZ domain, and produces one frame-buffer write per pixel. Write address and data use the same encoding the VGA read side consumes: address = row*640 + col (19 bits), data = {R[3:0],G[3:0],B[3:0]}.

## Interface
- H_PIXELS, 640, pixels per line written; extra pixels in a line are dropped
- V_LINES, 480, lines per frame written; extra lines are dropped
- CLK100MHZ  in  1  system clock; all logic on rising edge
- CPU_RESETN  in  1  asynchronous, active-low reset
- cam_pclk  in  1  camera pixel clock, asynchronous; ≤25 MHz, high and low phases each ≥2 CLK100MHZ periods
- cam_vsync  in  1  frame sync, active high between frames
- cam_href  in  1  line valid, active high
- cam_data  in  8  camera byte, stable around cam_pclk rising edge
- wen  out  1  frame-buffer write strobe, one cycle per pixel
- waddr  out  19  write address, row*640+col
- wdata  out  12  {R,G,B} 4 bits each
- frame_done  out  1  one-cycle pulse at end of each captured frame
- frame_ok  out  1  registered with frame_done: last frame had exactly V_LINES lines of exactly H_PIXELS pixels
- overflow  out  1  sticky: current frame exceeded H_PIXELS or V_LINES; cleared at frame start

## Operation
- cam_pclk, cam_vsync, cam_href, cam_data each pass through two synchroniser flops; a third flop on pclk/vsync/href gives edge detection. All decisions use synchronised values only.
- States: WAIT_VS_HI (wait synced vsync = 1), WAIT_VS_LO (wait vsync falling edge), CAPTURE. Reset enters WAIT_VS_HI, so a partial frame after reset is never written.
- WAIT_VS_LO -> CAPTURE on vsync fall: row=0, col=0, byte phase=0, overflow=0, line counter=0.
- In CAPTURE, on each pclk rising edge with synced href=1: phase 0 latches data[3:0] as R; phase 1 forms pixel {R, data[7:4], data[3:0]} and issues a write if row<V_LINES and col<H_PIXELS, else sets overflow. col increments per completed pixel (saturating at 1023, 10-bit).
- href falling edge: if col>0 then row increments (saturating at 511, 9-bit), line_complete tracking records whether col==H_PIXELS; col=0, phase=0. Odd byte at href fall is discarded.
- vsync rising edge in CAPTURE: pulse frame_done, set frame_ok = (rows==V_LINES and every line had col==H_PIXELS and !overflow), go to WAIT_VS_LO.
- waddr computed incrementally: line base += H_PIXELS per row, waddr = base + col; no multiplier.

## Timing
- Reset values: wen=0, waddr=0, wdata=0, frame_done=0, frame_ok=0, overflow=0, all synchronisers 0, state WAIT_VS_HI.
- Latency: wen/waddr/wdata are registered; wen is high during the cycle following the third CLK100MHZ edge after the edge that first samples cam_pclk=1 on the second byte of a pixel. waddr/wdata valid only while wen=1; hold last value otherwise.
- wen never high on consecutive cycles (pclk ≤25 MHz).
- frame_done asserted exactly one cycle, frame_ok updated on the same edge and held until next frame_done.
- Simultaneous pclk edge and href fall: pclk edge is ignored (synced href already 0).
- CPU_RESETN asserted mid-frame: outputs clear immediately; capture resumes only after a full vsync high->low.

## Configuration
- CAP_FRAME_SKIP_EN defined: a frame toggle flips at each vsync fall; odd frames are traversed (counters, overflow, frame_done, frame_ok all behave) but wen stays 0. Halves write bandwidth.
- Undefined: every frame written.

## Test plan
- Reset, then vsync 1->0, one line of 640 pixels, byte pairs 0x0A,0x5C -> 640 writes, waddr 0..639, wdata 0xA5C, no other wen.
- Full 640x480 frame of col/row pattern then vsync high -> 307200 writes, last waddr 307199, frame_done single pulse, frame_ok=1, overflow=0.
- Line of 642 pixels -> writes for col 0..639 only, overflow=1, frame_ok=0 at frame_done; overflow=0 after next vsync fall.
- href drops after 3 bytes -> one write (col 0), second pixel discarded; next line starts at waddr 640 with phase 0.
- CPU_RESETN low for 2 cycles mid-line -> wen=0 until after next vsync high->low; first subsequent write at waddr 0.
- With CAP_FRAME_SKIP_EN: two consecutive full frames -> 307200 writes total, two frame_done pulses, both frame_ok=1.

Source files
------------

// File: rtl/cam_capture_444_if.sv
// Frame-buffer write bus between the camera capture block and the frame buffer.
// The capture side drives it through the master modport; the buffer listens through slave.
interface cam_capture_444_if;
    logic        wen;
    logic [18:0] waddr;
    logic [11:0] wdata;

    modport master (output wen, output waddr, output wdata);
    modport slave  (input  wen, input  waddr, input  wdata);
endinterface

// File: rtl/cam_capture_444.sv
// OV7670-style RGB444 capture into the CLK100MHZ domain, one frame-buffer write per pixel.
// Optional build macro CAP_FRAME_SKIP_EN: write only every other frame.
module cam_capture_444 #(
    parameter int H_PIXELS = 640,
    parameter int V_LINES  = 480
) (
    input  logic                      CLK100MHZ,
    input  logic                      CPU_RESETN,
    input  logic                      cam_pclk,
    input  logic                      cam_vsync,
    input  logic                      cam_href,
    input  logic [7:0]                cam_data,
    cam_capture_444_if.master         fb,
    output logic                      frame_done,
    output logic                      frame_ok,
    output logic                      overflow
);

    typedef enum logic [1:0] {WAIT_VS_HI, WAIT_VS_LO, CAPTURE} state_t;

    localparam logic [9:0]  H_COL  = 10'(H_PIXELS);
    localparam logic [8:0]  V_ROW  = 9'(V_LINES);
    localparam logic [18:0] H_STEP = 19'(H_PIXELS);

    state_t      state, state_next;

    logic        pclk_p0, pclk_p1, pclk_p2;
    logic        vsync_p0, vsync_p1, vsync_p2;
    logic        href_p0, href_p1, href_p2;
    logic [7:0]  data_p0, data_p1;

    logic        pclk_rise_p3, href_p3, href_fall_p3;
    logic        vsync_p3, vsync_rise_p3, vsync_fall_p3;
    logic [7:0]  data_p3;

    logic        start_frame, end_frame, pix_byte, line_end;

    logic [9:0]  col;
    logic [8:0]  row;
    logic [18:0] line_base;
    logic        phase;
    logic [3:0]  red_lat;
    logic        all_lines_ok;
`ifdef CAP_FRAME_SKIP_EN
    logic        frame_tgl;
    logic        skip_frame;
`endif

    // Stage p0/p1: two-flop synchronisers; p2: history flop for edge detection
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            pclk_p0  <= 1'b0; pclk_p1  <= 1'b0; pclk_p2  <= 1'b0;
            vsync_p0 <= 1'b0; vsync_p1 <= 1'b0; vsync_p2 <= 1'b0;
            href_p0  <= 1'b0; href_p1  <= 1'b0; href_p2  <= 1'b0;
            data_p0  <= 8'd0; data_p1  <= 8'd0;
        end else begin
            pclk_p0  <= cam_pclk;  pclk_p1  <= pclk_p0;  pclk_p2  <= pclk_p1;
            vsync_p0 <= cam_vsync; vsync_p1 <= vsync_p0; vsync_p2 <= vsync_p1;
            href_p0  <= cam_href;  href_p1  <= href_p0;  href_p2  <= href_p1;
            data_p0  <= cam_data;  data_p1  <= data_p0;
        end
    end

    // Stage p3: registered edge events travel together with the byte they qualify
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            pclk_rise_p3  <= 1'b0;
            href_p3       <= 1'b0;
            href_fall_p3  <= 1'b0;
            vsync_p3      <= 1'b0;
            vsync_rise_p3 <= 1'b0;
            vsync_fall_p3 <= 1'b0;
            data_p3       <= 8'd0;
        end else begin
            pclk_rise_p3  <= pclk_p1 & ~pclk_p2;
            href_p3       <= href_p1;
            href_fall_p3  <= ~href_p1 & href_p2;
            vsync_p3      <= vsync_p1;
            vsync_rise_p3 <= vsync_p1 & ~vsync_p2;
            vsync_fall_p3 <= ~vsync_p1 & vsync_p2;
            data_p3       <= data_p1;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) state <= WAIT_VS_HI;
        else             state <= state_next;
    end

    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        case (state)
            WAIT_VS_HI: if (vsync_p3) state_next = WAIT_VS_LO;
            WAIT_VS_LO: if (vsync_fall_p3) begin
                state_next  = CAPTURE;
                start_frame = 1'b1;
            end
            CAPTURE: if (vsync_rise_p3) begin
                state_next = WAIT_VS_LO;
                end_frame  = 1'b1;
            end
            default: state_next = WAIT_VS_HI;
        endcase
        // href is already low when a pclk edge coincides with its fall, so that byte is ignored
        pix_byte = (state == CAPTURE) && pclk_rise_p3 && href_p3;
        line_end = (state == CAPTURE) && href_fall_p3;
    end

    // Stage p4: counters, address generation and registered write port
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            fb.wen       <= 1'b0;
            fb.waddr     <= 19'd0;
            fb.wdata     <= 12'd0;
            frame_done   <= 1'b0;
            frame_ok     <= 1'b0;
            overflow     <= 1'b0;
            col          <= 10'd0;
            row          <= 9'd0;
            line_base    <= 19'd0;
            phase        <= 1'b0;
            red_lat      <= 4'd0;
            all_lines_ok <= 1'b1;
`ifdef CAP_FRAME_SKIP_EN
            frame_tgl    <= 1'b0;
            skip_frame   <= 1'b0;
`endif
        end else begin
            fb.wen     <= 1'b0;
            frame_done <= 1'b0;
            if (start_frame) begin
                col          <= 10'd0;
                row          <= 9'd0;
                line_base    <= 19'd0;
                phase        <= 1'b0;
                overflow     <= 1'b0;
                all_lines_ok <= 1'b1;
`ifdef CAP_FRAME_SKIP_EN
                skip_frame   <= frame_tgl;
                frame_tgl    <= ~frame_tgl;
`endif
            end else begin
                if (pix_byte) begin
                    if (!phase) begin
                        red_lat <= data_p3[3:0];
                        phase   <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        if ((row < V_ROW) && (col < H_COL)) begin
`ifdef CAP_FRAME_SKIP_EN
                            fb.wen <= ~skip_frame;
`else
                            fb.wen <= 1'b1;
`endif
                            fb.waddr <= line_base + {9'd0, col};
                            fb.wdata <= {red_lat, data_p3};
                        end else begin
                            overflow <= 1'b1;
                        end
                        if (col != 10'h3FF) col <= col + 10'd1;
                    end
                end else if (line_end) begin
                    // A line with no completed pixel does not advance the row
                    if (col != 10'd0) begin
                        if (row != 9'h1FF) begin
                            row       <= row + 9'd1;
                            line_base <= line_base + H_STEP;
                        end
                        if (col != H_COL) all_lines_ok <= 1'b0;
                    end
                    col   <= 10'd0;
                    phase <= 1'b0;
                end
                if (end_frame) begin
                    frame_done <= 1'b1;
                    frame_ok   <= (row == V_ROW) && all_lines_ok && !overflow;
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_capture_444.sv
// Scoreboard bench for cam_capture_444 on a reduced 8x4 frame geometry.
module tb_cam_capture_444;

    localparam int H = 8;
    localparam int V = 4;

    logic       clk;
    logic       rst_n;
    logic       cam_pclk;
    logic       cam_vsync;
    logic       cam_href;
    logic [7:0] cam_data;
    logic       frame_done;
    logic       frame_ok;
    logic       overflow;

    cam_capture_444_if fb ();

    cam_capture_444 #(.H_PIXELS(H), .V_LINES(V)) dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .cam_pclk  (cam_pclk),
        .cam_vsync (cam_vsync),
        .cam_href  (cam_href),
        .cam_data  (cam_data),
        .fb        (fb),
        .frame_done(frame_done),
        .frame_ok  (frame_ok),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [30:0] exp_wr[$];
    logic [1:0]  exp_fd[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes or ends a frame
    logic prev_wen = 1'b0;
    logic prev_fd  = 1'b0;
    always @(negedge clk) begin
        logic [30:0] e;
        logic [1:0]  f;
        if (fb.wen === 1'b1) begin
            checks++;
            if (prev_wen) begin
                errors++;
                $display("FAIL wen_consecutive: got wen high two cycles, required single cycle");
            end
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %03h, required no write", fb.waddr, fb.wdata);
            end else begin
                e = exp_wr.pop_front();
                if ({fb.waddr, fb.wdata} !== e) begin
                    errors++;
                    $display("FAIL write: got addr %0d data %03h, required addr %0d data %03h",
                             fb.waddr, fb.wdata, e[30:12], e[11:0]);
                end
            end
        end
        if (frame_done === 1'b1) begin
            checks++;
            if (prev_fd) begin
                errors++;
                $display("FAIL frame_done_width: got pulse longer than one cycle, required one");
            end
            checks++;
            if (exp_fd.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame_done: got frame_done, required none");
            end else begin
                f = exp_fd.pop_front();
                if ({frame_ok, overflow} !== f) begin
                    errors++;
                    $display("FAIL frame_status: got ok=%0b ovf=%0b, required ok=%0b ovf=%0b",
                             frame_ok, overflow, f[1], f[0]);
                end
            end
        end
        prev_wen = fb.wen;
        prev_fd  = frame_done;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        cam_data = b;
        repeat (3) @(negedge clk);
        cam_pclk = 1'b1;
        repeat (3) @(negedge clk);
        cam_pclk = 1'b0;
    endtask

    // kind 0: constant 0x0A,0x5C pairs; kind 1: pattern R=row, G=col, B=row+col
    task automatic send_line(input int row, input int nbytes, input bit expect_wr,
                             input int kind, input bit drop_href);
        logic [7:0] b;
        logic [3:0] rn;
        int c;
        rn = 4'd0;
        cam_href = 1'b1;
        for (int k = 0; k < nbytes; k++) begin
            c = k / 2;
            if (k % 2 == 0) begin
                b  = (kind == 0) ? 8'h0A : {4'hF, 4'(row)};
                rn = b[3:0];
            end else begin
                b = (kind == 0) ? 8'h5C : {4'(c), 4'(row + c)};
                if (expect_wr && c < H && row < V)
                    exp_wr.push_back({19'(row * H + c), rn, b});
            end
            send_byte(b);
        end
        if (drop_href) begin
            cam_href = 1'b0;
            repeat (6) @(negedge clk);
        end
    endtask

    task automatic vs_end(input bit expect_fd, input logic [1:0] st);
        if (expect_fd) exp_fd.push_back(st);
        cam_vsync = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic vs_start();
        cam_vsync = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        cam_pclk  = 1'b0;
        cam_vsync = 1'b0;
        cam_href  = 1'b0;
        cam_data  = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_wen",        32'(fb.wen),     32'd0);
        chk("rst_waddr",      32'(fb.waddr),   32'd0);
        chk("rst_wdata",      32'(fb.wdata),   32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frame_ok",   32'(frame_ok),   32'd0);
        chk("rst_overflow",   32'(overflow),   32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Full frame: row 0 constant A5C, remaining rows patterned
        vs_end(1'b0, 2'b00);
        vs_start();
        send_line(0, 2 * H, 1'b1, 0, 1'b1);
        for (int r = 1; r < V; r++) send_line(r, 2 * H, 1'b1, 1, 1'b1);
        vs_end(1'b1, 2'b10);

        // Reset mid-line: nothing written until a fresh vsync high->low
        vs_start();
        send_line(0, 6, 1'b1, 1, 1'b0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_wen",        32'(fb.wen),     32'd0);
        chk("midrst_waddr",      32'(fb.waddr),   32'd0);
        chk("midrst_wdata",      32'(fb.wdata),   32'd0);
        chk("midrst_frame_ok",   32'(frame_ok),   32'd0);
        chk("midrst_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_line(0, 10, 1'b0, 1, 1'b1);
        send_line(1, 2 * H, 1'b0, 1, 1'b1);
        vs_end(1'b0, 2'b00);
        vs_start();
        for (int r = 0; r < V; r++) send_line(r, 2 * H, 1'b1, 1, 1'b1);
        vs_end(1'b1, 2'b10);

        // Overlong line: two extra pixels dropped and flagged
        vs_start();
        send_line(0, 2 * (H + 2), 1'b1, 1, 1'b1);
        for (int r = 1; r < V; r++) send_line(r, 2 * H, 1'b1, 1, 1'b1);
        vs_end(1'b1, 2'b01);

        // Next frame start clears overflow; first line cut after three bytes
        vs_start();
        chk("overflow_cleared", 32'(overflow), 32'd0);
        send_line(0, 3, 1'b1, 1, 1'b1);
        send_line(1, 2 * H, 1'b1, 1, 1'b1);
        vs_end(1'b1, 2'b00);

        repeat (20) @(negedge clk);
        chk("writes_left", 32'(exp_wr.size()), 32'd0);
        chk("frames_left", 32'(exp_fd.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
